// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: grants one functional-unit result per cycle
// and drives it onto a registered bus. Define CDB_ARBITER_PERF_EN for perf counters.
module cdb_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*3-1:0]        req_tag,
    input  logic [NUM_REQ*32-1:0]       req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        cdb_valid,
    output logic [34:0]                 cdb_out,
    output logic [$clog2(NUM_REQ)-1:0]  cdb_src
`ifdef CDB_ARBITER_PERF_EN
    ,
    output logic [31:0]                 perf_grants,
    output logic [31:0]                 perf_conflicts
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW:0]   NUM_REQ_W = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

    // True when two or more request bits are set (clearing the lowest set bit leaves a residue).
    function automatic logic multi_hot(input logic [NUM_REQ-1:0] v);
        return ((v & (v - NUM_REQ'(1))) != '0);
    endfunction

    logic [IW-1:0]      r_ptr;
    logic               r_cdb_valid;
    logic [34:0]        r_cdb_out;
    logic [IW-1:0]      r_cdb_src;

    logic [IW:0]        w_cand;
    logic               w_found;
    logic [IW-1:0]      w_gidx;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_grant;
    logic [2:0]         w_tag_sel;
    logic [31:0]        w_data_sel;
    logic [IW-1:0]      w_ptr_next;

    // Scan from the priority pointer with modular wrap; the first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_cand >= NUM_REQ_W) begin
                w_cand = w_cand - NUM_REQ_W;
            end else begin
                w_cand = w_cand;
            end
            if (!w_found && req_valid[w_cand[IW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_cand[IW-1:0];
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_xfer = rst && !flush && w_found;

    // Grant is suppressed during reset and flush, so no transfer can happen then.
    always_comb begin
        w_grant = '0;
        if (w_xfer) begin
            w_grant[w_gidx] = 1'b1;
        end else begin
            w_grant = '0;
        end
    end

    assign req_ready  = w_grant;
    assign w_tag_sel  = req_tag[w_gidx*3 +: 3];
    assign w_data_sel = req_data[w_gidx*32 +: 32];
    assign w_ptr_next = (w_gidx == LAST_IDX) ? '0 : (w_gidx + IW'(1));

    // Bus register and priority pointer; non-transfer cycles hold word/source and drop valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cdb_valid <= 1'b0;
            r_cdb_out   <= 35'd0;
            r_cdb_src   <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_cdb_valid <= 1'b1;
                r_cdb_out   <= {w_tag_sel, w_data_sel};
                r_cdb_src   <= w_gidx;
                r_ptr       <= w_ptr_next;
            end else begin
                r_cdb_valid <= 1'b0;
            end
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_out   = r_cdb_out;
    assign cdb_src   = r_cdb_src;

`ifdef CDB_ARBITER_PERF_EN
    logic [31:0] r_perf_grants;
    logic [31:0] r_perf_conflicts;
    logic        w_conflict;

    assign w_conflict = !flush && multi_hot(req_valid);

    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_grants    <= 32'd0;
            r_perf_conflicts <= 32'd0;
        end else begin
            if (w_xfer) begin
                r_perf_grants <= r_perf_grants + 32'd1;
            end else begin
                r_perf_grants <= r_perf_grants;
            end
            if (w_conflict) begin
                r_perf_conflicts <= r_perf_conflicts + 32'd1;
            end else begin
                r_perf_conflicts <= r_perf_conflicts;
            end
        end
    end

    assign perf_grants    = r_perf_grants;
    assign perf_conflicts = r_perf_conflicts;
`endif

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of functional-unit requesters (2..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low (asserted when 0).
REQ-004 flush  input  1  squash: block all grants this cycle and invalidate the bus.
REQ-005 req_valid  input  NUM_REQ  per-requester broadcast request.
REQ-006 req_tag  input  NUM_REQ x 3  per-requester destination tag.
REQ-007 req_data  input  NUM_REQ x 32  per-requester result data.
REQ-008 req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
REQ-009 cdb_valid  output  1  registered bus-valid.
REQ-010 cdb_out  output  35  registered bus word: tag[34:32], data[31:0].
REQ-011 cdb_src  output  $clog2(NUM_REQ)  index of the requester that drove cdb_out.

Function
REQ-012 Arbitration SHALL be round-robin from priority pointer ptr: the first i in ptr, ptr+1, ..., ptr+NUM_REQ-1 (mod NUM_REQ) with req_valid[i]=1 is granted.
REQ-013 req_ready SHALL be combinational from req_valid, ptr and flush; at most one bit set per cycle.
REQ-014 Transfer SHALL occur when req_valid[i] and req_ready[i] are both 1 in the same cycle.
REQ-015 Requesters SHALL hold valid, tag and data stable until transfer; the arbiter never drops an accepted word.
REQ-016 On transfer by i, the next edge SHALL load cdb_valid=1, cdb_out={req_tag[i],req_data[i]}, cdb_src=i (latency 1 cycle).
REQ-017 On transfer by i, ptr SHALL become (i+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0.
REQ-018 With no transfer, cdb_valid SHALL be 0 at the next edge; cdb_out and cdb_src hold their previous values; ptr unchanged.
REQ-019 cdb_valid SHALL be high for exactly one cycle per transfer; back-to-back transfers give back-to-back valid cycles.
REQ-020 flush=1 SHALL force req_ready=0, load cdb_valid=0 at the next edge, and leave ptr unchanged.
REQ-021 A single persistent requester SHALL be granted every cycle (100% bus utilization).
REQ-022 With all NUM_REQ requesters valid, each requester SHALL be granted exactly once in every NUM_REQ consecutive grant cycles.

Reset
REQ-023 When rst=0 at a rising edge: cdb_valid=0, cdb_out=0, cdb_src=0, ptr=0, and all counters = 0.
REQ-024 req_ready SHALL be 0 in any cycle in which rst=0, so no transfer occurs during reset.
REQ-025 Reset asserted mid-stream SHALL discard any in-flight bus word; the requester retries after reset is released.

Configuration
REQ-026 Macro CDB_ARBITER_PERF_EN SHALL compile in the performance counters.
REQ-027 With the macro defined: outputs perf_grants (32), incremented once per transfer, and perf_conflicts (32), incremented in each cycle with two or more req_valid bits set and flush=0; both wrap modulo 2^32.
REQ-028 Without the macro: the perf ports and counter logic are absent, and all other behaviour is identical.

Verification
REQ-029 Reset: hold rst=0 for 2 cycles with req_valid=4'b1111 -> req_ready=0, cdb_valid=0, cdb_out=0.
REQ-030 Single requester: req_valid=4'b0100, tag=3'd5, data=32'hDEADBEEF for 3 cycles -> cdb_valid=1 for 3 cycles starting 1 cycle later, each with cdb_out={3'd5,32'hDEADBEEF} and cdb_src=2.
REQ-031 Full contention: req_valid=4'b1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; with PERF_EN, perf_conflicts=8 and perf_grants=8.
REQ-032 Wrap and skip: ptr=3, req_valid=4'b0101 -> grant 0, then grant 2, then grant 0.
REQ-033 Flush: flush=1 in the same cycle as req_valid=4'b0010 -> req_ready=0 and cdb_valid=0 at the next edge; flush=0 in the following cycle -> requester 1 granted.
REQ-034 Mid-stream reset: assert rst=0 in the cycle after requester 3 is granted -> cdb_valid=0 and ptr=0 at the next edge; after release, requester 3 (still valid) is granted first only if no lower index is valid.
